alu_src_control: RTL and testbench

Multicycle control sequencer for the datapath's ALU operand muxes. It drives the 3-bit ALUSrcB select and the ALUSrcA select consumed by the operand muxes, along with the ALU operation code and the PC, IR and register-file write enables. It steps each instruction through fetch, decode, execute and write-back. It sits between the instruction register (opcode/funct source) and the ALU-side muxes, and counts retired instructions.

---
 rtl/alu_src_control_if.sv | 34 +++
 rtl/alu_src_control.sv | 212 +++++++++++++++++++++
 tb/tb_alu_src_control.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_src_control_if.sv
// rtl/alu_src_control_if.sv - instruction-in / control-out bundle for the ALU source sequencer
interface alu_src_control_if #(
    parameter int COUNT_W = 32
);
    logic [5:0]         Opcode;
    logic [5:0]         Funct;
    logic               MemReady;
    logic               ALUSrcA;
    logic [2:0]         ALUSrcB;
    logic [2:0]         ALUOp;
    logic               IRWrite;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               RegWrite;
    logic               RegDst;
    logic               InstrDone;
    logic               IllegalOp;
    logic [COUNT_W-1:0] InstrCount;

    // Instruction source side: drives opcode/funct and memory readiness
    modport master (
        output Opcode, Funct, MemReady,
        input  ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite, PCWriteCond,
               BranchNe, RegWrite, RegDst, InstrDone, IllegalOp, InstrCount
    );

    // Sequencer side: consumes the instruction fields, drives the datapath controls
    modport slave (
        input  Opcode, Funct, MemReady,
        output ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite, PCWriteCond,
               BranchNe, RegWrite, RegDst, InstrDone, IllegalOp, InstrCount
    );
endinterface

// File: rtl/alu_src_control.sv
// rtl/alu_src_control.sv - multicycle sequencer for ALU operand muxes, ALU op and write enables
module alu_src_control #(
    parameter int COUNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_src_control_if.slave ctl
);
    typedef enum logic [3:0] {
        stRst,
        stFetch,
        stDecode,
        stExecR,
        stExecI,
        stExecIu,
        stBranch,
        stWbR,
        stWbI,
        stIllegal
    } stateType;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    localparam logic [2:0] SRCB_REG  = 3'd0;
    localparam logic [2:0] SRCB_FOUR = 3'd1;
    localparam logic [2:0] SRCB_SEXT = 3'd2;
    localparam logic [2:0] SRCB_BDST = 3'd3;
    localparam logic [2:0] SRCB_ZEXT = 3'd4;

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    stateType           state;
    stateType           nextState;
    logic [5:0]         opcodeLatched;
    logic [5:0]         functLatched;
    logic [COUNT_W-1:0] instrCount;

    logic               aluSrcA;
    logic [2:0]         aluSrcB;
    logic [2:0]         aluOp;
    logic               irWrite;
    logic               pcWrite;
    logic               pcWriteCond;
    logic               branchNe;
    logic               regWrite;
    logic               regDst;
    logic               instrDone;
    logic               illegalOp;
    logic               functOk;
    logic [2:0]         rTypeOp;

    // R-type funct decode: supported flag and the ALU operation it selects
    always_comb begin
        functOk = 1'b1;
        rTypeOp = ALU_NONE;
        case (functLatched)
            FN_ADD:  rTypeOp = ALU_ADD;
            FN_SUB:  rTypeOp = ALU_SUB;
            FN_AND:  rTypeOp = ALU_AND;
            FN_OR:   rTypeOp = ALU_OR;
            FN_SLT:  rTypeOp = ALU_SLT;
            default: functOk = 1'b0;
        endcase
    end

    // State register; reset parks the sequencer in RST from any state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= stRst;
        end else begin
            state <= nextState;
        end
    end

    // Capture opcode/funct on the edge that enters DECODE so later IR changes are ignored
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opcodeLatched <= 6'h00;
            functLatched  <= 6'h00;
        end else if (state == stFetch && ctl.MemReady) begin
            opcodeLatched <= ctl.Opcode;
            functLatched  <= ctl.Funct;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instrCount <= '0;
        end else if (instrDone) begin
            instrCount <= instrCount + COUNT_ONE;
        end
    end

    // Next-state and state-decoded control outputs
    always_comb begin
        nextState   = state;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_REG;
        aluOp       = ALU_NONE;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        branchNe    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        case (state)
            stRst: begin
                nextState = stFetch;
            end
            stFetch: begin
                aluSrcB = SRCB_FOUR;
                aluOp   = ALU_ADD;
                if (ctl.MemReady) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = stDecode;
                end
            end
            stDecode: begin
                aluSrcB = SRCB_BDST;
                aluOp   = ALU_ADD;
                case (opcodeLatched)
                    OP_RTYPE:        nextState = functOk ? stExecR : stIllegal;
                    OP_ADDI:         nextState = stExecI;
                    OP_ANDI, OP_ORI: nextState = stExecIu;
                    OP_BEQ, OP_BNE:  nextState = stBranch;
                    default:         nextState = stIllegal;
                endcase
            end
            stExecR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_REG;
                aluOp     = rTypeOp;
                nextState = stWbR;
            end
            stExecI: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_SEXT;
                aluOp     = ALU_ADD;
                nextState = stWbI;
            end
            stExecIu: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_ZEXT;
                aluOp     = (opcodeLatched == OP_ORI) ? ALU_OR : ALU_AND;
                nextState = stWbI;
            end
            stBranch: begin
                aluSrcA     = 1'b1;
                aluSrcB     = SRCB_REG;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                branchNe    = (opcodeLatched == OP_BNE);
                instrDone   = 1'b1;
                nextState   = stFetch;
            end
            stWbR: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
                nextState = stFetch;
            end
            stWbI: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                nextState = stFetch;
            end
            stIllegal: begin
                illegalOp = 1'b1;
                instrDone = 1'b1;
                nextState = stFetch;
            end
            default: begin
                nextState = stRst;
            end
        endcase
    end

    assign ctl.ALUSrcA     = aluSrcA;
    assign ctl.ALUSrcB     = aluSrcB;
    assign ctl.ALUOp       = aluOp;
    assign ctl.IRWrite     = irWrite;
    assign ctl.PCWrite     = pcWrite;
    assign ctl.PCWriteCond = pcWriteCond;
    assign ctl.BranchNe    = branchNe;
    assign ctl.RegWrite    = regWrite;
    assign ctl.RegDst      = regDst;
    assign ctl.InstrDone   = instrDone;
    assign ctl.IllegalOp   = illegalOp;
    assign ctl.InstrCount  = instrCount;
endmodule

// File: tb/tb_alu_src_control.sv
// tb/tb_alu_src_control.sv - directed bench for the ALU source sequencer
module tb_alu_src_control;
    logic clk = 1'b0;
    logic reset_n;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    alu_src_control_if #(.COUNT_W(4)) bus ();

    alu_src_control #(.COUNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctl     (bus)
    );

    // Packed view: {ALUSrcA, ALUSrcB[2:0], ALUOp[2:0], IRWrite, PCWrite, PCWriteCond,
    //               BranchNe, RegWrite, RegDst, InstrDone, IllegalOp}
    localparam logic [14:0] O_ZERO      = 15'b0_000_000_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_FETCH_RDY = 15'b0_001_001_1_1_0_0_0_0_0_0;
    localparam logic [14:0] O_FETCH_WT  = 15'b0_001_001_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_DECODE    = 15'b0_011_001_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_EXEC_ADD  = 15'b1_000_001_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_EXEC_SUB  = 15'b1_000_010_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_EXEC_ADDI = 15'b1_010_001_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_EXEC_ORI  = 15'b1_100_100_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_WB_R      = 15'b0_000_000_0_0_0_0_1_1_1_0;
    localparam logic [14:0] O_WB_I      = 15'b0_000_000_0_0_0_0_1_0_1_0;
    localparam logic [14:0] O_BR_NE     = 15'b1_000_010_0_0_1_1_0_0_1_0;
    localparam logic [14:0] O_BR_EQ     = 15'b1_000_010_0_0_1_0_0_0_1_0;
    localparam logic [14:0] O_ILL       = 15'b0_000_000_0_0_0_0_0_0_1_1;

    function automatic logic [14:0] outs();
        return {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.BranchNe, bus.RegWrite, bus.RegDst,
                bus.InstrDone, bus.IllegalOp};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-wide invariants: PC write enables exclusive, no RegWrite with IRWrite, ALUSrcB in range
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            testsRun++;
            if ((bus.PCWrite && bus.PCWriteCond) || (bus.RegWrite && bus.IRWrite) || (bus.ALUSrcB > 3'd4)) begin
                $display("FAIL invariant at %0t: PCWrite=%b PCWriteCond=%b RegWrite=%b IRWrite=%b ALUSrcB=%0d required exclusive enables and ALUSrcB<=4",
                         $time, bus.PCWrite, bus.PCWriteCond, bus.RegWrite, bus.IRWrite, bus.ALUSrcB);
                testsFailed++;
            end
        end
    end

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h00;
        bus.MemReady = 1'b0;
        tick();
        tick();
        testsRun++;
        if (outs() !== O_ZERO || bus.InstrCount !== 4'd0) begin
            $display("FAIL reset: outs=%b count=%0d required %b count=0", outs(), bus.InstrCount, O_ZERO);
            testsFailed++;
        end
        reset_n = 1'b1;
        tick();
        testsRun++;
        if (outs() !== O_FETCH_WT) begin
            $display("FAIL reset_first_fetch: outs=%b required %b", outs(), O_FETCH_WT);
            testsFailed++;
        end
    endtask

    task automatic test_add();
        logic [14:0] exp [4] = '{O_FETCH_RDY, O_DECODE, O_EXEC_ADD, O_WB_R};
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h20;
        bus.MemReady = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 1) begin
                bus.Opcode = 6'h23;
                bus.Funct  = 6'h22;
            end
            testsRun++;
            if (outs() !== exp[i]) begin
                $display("FAIL add cycle %0d: outs=%b required %b", i, outs(), exp[i]);
                testsFailed++;
            end
        end
        tick();
        testsRun++;
        if (bus.InstrCount !== 4'd1) begin
            $display("FAIL add_count: count=%0d required 1", bus.InstrCount);
            testsFailed++;
        end
    endtask

    task automatic test_addi_ori();
        logic [14:0] exp [8] = '{O_FETCH_RDY, O_DECODE, O_EXEC_ADDI, O_WB_I,
                                 O_FETCH_RDY, O_DECODE, O_EXEC_ORI, O_WB_I};
        int dones = 0;
        bus.Opcode   = 6'h08;
        bus.MemReady = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            if (i == 4) bus.Opcode = 6'h0D;
            if (bus.InstrDone === 1'b1) dones++;
            testsRun++;
            if (outs() !== exp[i]) begin
                $display("FAIL addi_ori cycle %0d: outs=%b required %b", i, outs(), exp[i]);
                testsFailed++;
            end
        end
        tick();
        testsRun++;
        if (dones != 2 || bus.InstrCount !== 4'd3) begin
            $display("FAIL addi_ori_retire: dones=%0d count=%0d required 2 and 3", dones, bus.InstrCount);
            testsFailed++;
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp [6] = '{O_FETCH_RDY, O_DECODE, O_BR_NE, O_FETCH_RDY, O_DECODE, O_BR_EQ};
        bus.Opcode   = 6'h05;
        bus.MemReady = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (i == 3) bus.Opcode = 6'h04;
            testsRun++;
            if (outs() !== exp[i]) begin
                $display("FAIL branch cycle %0d: outs=%b required %b", i, outs(), exp[i]);
                testsFailed++;
            end
        end
        tick();
        testsRun++;
        if (bus.InstrCount !== 4'd5) begin
            $display("FAIL branch_count: count=%0d required 5", bus.InstrCount);
            testsFailed++;
        end
    endtask

    task automatic test_mem_wait();
        logic [14:0] exp [4] = '{O_FETCH_RDY, O_DECODE, O_EXEC_ADDI, O_WB_I};
        bus.Opcode   = 6'h08;
        bus.Funct    = 6'h00;
        bus.MemReady = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            testsRun++;
            if (outs() !== O_FETCH_WT) begin
                $display("FAIL mem_wait cycle %0d: outs=%b required %b", i, outs(), O_FETCH_WT);
                testsFailed++;
            end
        end
        tick();
        bus.MemReady = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 1) bus.MemReady = 1'b0;
            testsRun++;
            if (outs() !== exp[i]) begin
                $display("FAIL mem_wait_run cycle %0d: outs=%b required %b", i, outs(), exp[i]);
                testsFailed++;
            end
        end
        tick();
        bus.MemReady = 1'b1;
        testsRun++;
        if (bus.InstrCount !== 4'd6) begin
            $display("FAIL mem_wait_count: count=%0d required 6", bus.InstrCount);
            testsFailed++;
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [2] = '{6'h23, 6'h00};
        logic [5:0]  fns [2] = '{6'h20, 6'h00};
        logic [14:0] exp [3] = '{O_FETCH_RDY, O_DECODE, O_ILL};
        for (int k = 0; k < 2; k++) begin
            bus.Opcode   = ops[k];
            bus.Funct    = fns[k];
            bus.MemReady = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (i > 0) tick();
                testsRun++;
                if (outs() !== exp[i]) begin
                    $display("FAIL illegal%0d cycle %0d: outs=%b required %b", k, i, outs(), exp[i]);
                    testsFailed++;
                end
            end
            tick();
            testsRun++;
            if (outs() !== O_FETCH_RDY || bus.InstrCount !== 4'(7 + k)) begin
                $display("FAIL illegal%0d_after: outs=%b count=%0d required %b count=%0d",
                         k, outs(), bus.InstrCount, O_FETCH_RDY, 7 + k);
                testsFailed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp [3] = '{O_FETCH_RDY, O_DECODE, O_EXEC_SUB};
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h22;
        bus.MemReady = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            testsRun++;
            if (outs() !== exp[i]) begin
                $display("FAIL reset_mid cycle %0d: outs=%b required %b", i, outs(), exp[i]);
                testsFailed++;
            end
        end
        reset_n = 1'b0;
        tick();
        testsRun++;
        if (outs() !== O_ZERO || bus.InstrCount !== 4'd0) begin
            $display("FAIL reset_mid_clear: outs=%b count=%0d required %b count=0", outs(), bus.InstrCount, O_ZERO);
            testsFailed++;
        end
        reset_n = 1'b1;
        tick();
        testsRun++;
        if (outs() !== O_FETCH_RDY) begin
            $display("FAIL reset_mid_fetch: outs=%b required %b", outs(), O_FETCH_RDY);
            testsFailed++;
        end
    endtask

    task automatic test_back_to_back();
        int lastDone = -1;
        int dones = 0;
        bus.Opcode   = 6'h05;
        bus.MemReady = 1'b1;
        #1;
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (cyc > 0) tick();
            if (bus.InstrDone === 1'b1) begin
                dones++;
                if (lastDone >= 0) begin
                    testsRun++;
                    if (cyc - lastDone != 3) begin
                        $display("FAIL b2b_gap at cycle %0d: gap=%0d required 3", cyc, cyc - lastDone);
                        testsFailed++;
                    end
                end
                lastDone = cyc;
            end
        end
        testsRun++;
        if (dones != 16 || bus.InstrCount !== 4'd15) begin
            $display("FAIL b2b_before_wrap: dones=%0d count=%0d required 16 and 15", dones, bus.InstrCount);
            testsFailed++;
        end
        tick();
        testsRun++;
        if (bus.InstrCount !== 4'd0) begin
            $display("FAIL b2b_wrap: count=%0d required 0", bus.InstrCount);
            testsFailed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_ori();
        test_branch();
        test_mem_wait();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
